// File: rtl/jt900h_cregs.sv
// jt900h_cregs: TLCS-900H micro-DMA and INTNEST control registers, plus the
// sequencer that hands one DMA transfer at a time to the bus unit.
module jt900h_cregs (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [7:0]  cra,
  input  logic [31:0] crin,
  input  logic        cr_we,
  input  logic        cr_rd,
  output logic [31:0] cr,
  input  logic [3:0]  dma_req,
  output logic        dma_go,
  output logic [1:0]  dma_ch,
  output logic [31:0] dma_src,
  output logic [31:0] dma_dst,
  output logic [1:0]  dma_size,
  input  logic        dma_ack,
  output logic [3:0]  dma_end,
  input  logic        nest_inc,
  input  logic        nest_dec
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_UPD} state_t;

  localparam logic [2:0] MODE_DST_INC = 3'b000;
  localparam logic [2:0] MODE_DST_DEC = 3'b001;
  localparam logic [2:0] MODE_SRC_INC = 3'b010;
  localparam logic [2:0] MODE_SRC_DEC = 3'b011;
  localparam logic [2:0] MODE_COUNTER = 3'b101;

  state_t      state, state_nx;
  logic [31:0] dmas [4];
  logic [31:0] dmad [4];
  logic [15:0] dmac [4];
  logic [7:0]  dmam [4];
  logic [15:0] intnest;
  logic [3:0]  pend;
  logic [3:0]  upd_mask;
  logic [1:0]  cur_ch, low_ch;
  logic [1:0]  cur_size;
  logic [2:0]  cur_mode;
  logic [31:0] step;
  logic [15:0] dmac_nx;
  logic [31:0] rd_data;
  logic [1:0]  idx;
  logic        is_s, is_d, is_c, is_m, is_nest;

  assign idx     = cra[3:2];
  assign is_s    = (cra[7:4] == 4'h0) && (cra[1:0] == 2'b00);
  assign is_d    = (cra[7:4] == 4'h1) && (cra[1:0] == 2'b00);
  assign is_c    = (cra[7:4] == 4'h2) && (cra[1:0] == 2'b00);
  assign is_m    = (cra[7:4] == 4'h2) && (cra[1:0] == 2'b10);
  assign is_nest = (cra == 8'h3C);

  always_comb begin
    rd_data = 32'd0;
    if (is_s)    rd_data = dmas[idx];
    if (is_d)    rd_data = dmad[idx];
    if (is_c)    rd_data = {16'd0, dmac[idx]};
    if (is_m)    rd_data = {24'd0, dmam[idx]};
    if (is_nest) rd_data = {16'd0, intnest};
  end

  always_comb begin
    low_ch = 2'd3;
    if (pend[0])      low_ch = 2'd0;
    else if (pend[1]) low_ch = 2'd1;
    else if (pend[2]) low_ch = 2'd2;
  end

  // Size code 3 is promoted to long; step is the byte count of one transfer
  assign cur_size = (dmam[cur_ch][1:0] == 2'd3) ? 2'd2 : dmam[cur_ch][1:0];
  assign cur_mode = dmam[cur_ch][4:2];
  assign step     = 32'd1 << cur_size;
  assign dmac_nx  = dmac[cur_ch] - 16'd1;
  assign upd_mask = (state == ST_UPD) ? (4'b0001 << cur_ch) : 4'b0000;

  always_comb begin
    state_nx = state;
    dma_go   = 1'b0;
    case (state)
      ST_IDLE: if (pend != 4'd0) state_nx = ST_LOAD;
      ST_LOAD: state_nx = (cur_mode == MODE_COUNTER) ? ST_UPD : ST_WAIT;
      ST_WAIT: begin
        dma_go = 1'b1;
        if (dma_ack) state_nx = ST_UPD;
      end
      ST_UPD:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= ST_IDLE;
    else if (cen) state <= state_nx;
  end

  // CPU writes come last so they override a same-cycle sequencer update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        dmas[i] <= 32'd0;
        dmad[i] <= 32'd0;
        dmac[i] <= 16'd0;
        dmam[i] <= 8'd0;
      end
      intnest  <= 16'd0;
      pend     <= 4'd0;
      cur_ch   <= 2'd0;
      cr       <= 32'd0;
      dma_ch   <= 2'd0;
      dma_src  <= 32'd0;
      dma_dst  <= 32'd0;
      dma_size <= 2'd0;
      dma_end  <= 4'd0;
    end else if (cen) begin
      dma_end <= 4'd0;
      pend    <= (pend & ~upd_mask) | dma_req;
      if (state == ST_IDLE) cur_ch <= low_ch;
      if (state == ST_LOAD) begin
        dma_ch   <= cur_ch;
        dma_src  <= dmas[cur_ch];
        dma_dst  <= dmad[cur_ch];
        dma_size <= cur_size;
      end
      if (state == ST_UPD) begin
        dmac[cur_ch] <= dmac_nx;
        if (dmac_nx == 16'd0) dma_end <= upd_mask;
        case (cur_mode)
          MODE_DST_INC: dmad[cur_ch] <= dmad[cur_ch] + step;
          MODE_DST_DEC: dmad[cur_ch] <= dmad[cur_ch] - step;
          MODE_SRC_INC: dmas[cur_ch] <= dmas[cur_ch] + step;
          MODE_SRC_DEC: dmas[cur_ch] <= dmas[cur_ch] - step;
          MODE_COUNTER: dmas[cur_ch] <= dmas[cur_ch] + 32'd1;
          default: ;
        endcase
      end
      if (cr_we) begin
        if (is_s) dmas[idx] <= crin;
        if (is_d) dmad[idx] <= crin;
        if (is_c) dmac[idx] <= crin[15:0];
        if (is_m) dmam[idx] <= crin[7:0];
      end
      if (cr_we && is_nest)
        intnest <= crin[15:0];
      else if (nest_inc && !nest_dec && intnest != 16'hFFFF)
        intnest <= intnest + 16'd1;
      else if (nest_dec && !nest_inc && intnest != 16'h0000)
        intnest <= intnest - 16'd1;
      if (cr_rd) cr <= rd_data;
    end
  end

endmodule

// File: tb/tb_jt900h_cregs.sv
// tb_jt900h_cregs: directed bench for the JT900H control registers and
// micro-DMA sequencer; reads and transfers are checked through queues.
`timescale 1ns/1ps
module tb_jt900h_cregs;

  logic        clk = 1'b0;
  logic        rst, cen, cr_we, cr_rd, dma_ack, nest_inc, nest_dec, dma_go;
  logic [7:0]  cra;
  logic [31:0] crin, cr, dma_src, dma_dst;
  logic [3:0]  dma_req, dma_end;
  logic [1:0]  dma_ch, dma_size;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [1:0]  size;
    logic [3:0]  endv;
  } xfer_t;

  logic [31:0] rd_q[$];
  string       rd_tag_q[$];
  xfer_t       xfer_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          waited, go_cnt;

  jt900h_cregs dut (
    .clk(clk), .rst(rst), .cen(cen), .cra(cra), .crin(crin),
    .cr_we(cr_we), .cr_rd(cr_rd), .cr(cr), .dma_req(dma_req),
    .dma_go(dma_go), .dma_ch(dma_ch), .dma_src(dma_src), .dma_dst(dma_dst),
    .dma_size(dma_size), .dma_ack(dma_ack), .dma_end(dma_end),
    .nest_inc(nest_inc), .nest_dec(nest_dec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic rd,
                               input logic [7:0] addr, input logic [31:0] data);
    cr_we = we; cr_rd = rd; cra = addr; crin = data;
    tick();
    cr_we = 1'b0; cr_rd = 1'b0; cra = 8'd0; crin = 32'd0;
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr,
                           input logic [31:0] expected);
    rd_q.push_back(expected);
    rd_tag_q.push_back(tag);
    applyStimulus(1'b0, 1'b1, addr, 32'd0);
    checkOutput(rd_tag_q.pop_front(), cr, rd_q.pop_front());
  endtask

  task automatic pushXfer(input logic [1:0] ch, input logic [31:0] src,
                          input logic [31:0] dst, input logic [1:0] size,
                          input logic [3:0] endv);
    xfer_t e;
    e.ch = ch; e.src = src; e.dst = dst; e.size = size; e.endv = endv;
    xfer_q.push_back(e);
  endtask

  task automatic pulseReq(input logic [3:0] mask);
    dma_req = mask;
    tick();
    dma_req = 4'd0;
  endtask

  task automatic waitGo(output int cycles);
    cycles = 0;
    while (dma_go !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("go_seen", 32'(dma_go), 32'd1);
  endtask

  // Waits for dma_go, checks it against the oldest expected transfer, acks it
  task automatic serviceOne(output int cycles);
    xfer_t e;
    waitGo(cycles);
    if (xfer_q.size() > 0) e = xfer_q.pop_front();
    else begin
      e.ch = 2'b11; e.src = '1; e.dst = '1; e.size = 2'b11; e.endv = 4'hF;
    end
    checkOutput("xfer_ch",   32'(dma_ch),   32'(e.ch));
    checkOutput("xfer_src",  dma_src,       e.src);
    checkOutput("xfer_dst",  dma_dst,       e.dst);
    checkOutput("xfer_size", 32'(dma_size), 32'(e.size));
    tick();
    checkOutput("go_hold", 32'(dma_go), 32'd1);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    checkOutput("go_drop", 32'(dma_go), 32'd0);
    tick();
    checkOutput("xfer_end", 32'(dma_end), 32'(e.endv));
    tick();
    checkOutput("end_clear", 32'(dma_end), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; cr_we = 1'b0; cr_rd = 1'b0; cra = 8'd0; crin = 32'd0;
    dma_req = 4'd0; dma_ack = 1'b0; nest_inc = 1'b0; nest_dec = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_cr",     cr,              32'd0);
    checkOutput("rst_go",     32'(dma_go),     32'd0);
    checkOutput("rst_ch",     32'(dma_ch),     32'd0);
    checkOutput("rst_src",    dma_src,         32'd0);
    checkOutput("rst_dst",    dma_dst,         32'd0);
    checkOutput("rst_size",   32'(dma_size),   32'd0);
    checkOutput("rst_end",    32'(dma_end),    32'd0);
    readCheck("rst_nest", 8'h3C, 32'd0);

    // Register access, narrow writes, unmapped addresses
    writeReg(8'h04, 32'h00123456);
    readCheck("dmas1_rd", 8'h04, 32'h00123456);
    tick();
    checkOutput("cr_hold", cr, 32'h00123456);
    writeReg(8'h22, 32'h0000ABCD);
    readCheck("dmam0_narrow", 8'h22, 32'h000000CD);
    readCheck("dmac0_untouched", 8'h20, 32'd0);
    writeReg(8'h01, 32'hFFFFFFFF);
    readCheck("unmapped_wr", 8'h00, 32'd0);
    writeReg(8'h30, 32'hFFFFFFFF);
    readCheck("unmapped_rd", 8'h30, 32'd0);

    // Channel 0, word, dst increment, two transfers
    writeReg(8'h00, 32'h1000);
    writeReg(8'h10, 32'h2000);
    writeReg(8'h20, 32'd2);
    writeReg(8'h22, 32'h01);
    pushXfer(2'd0, 32'h1000, 32'h2000, 2'd1, 4'b0000);
    pulseReq(4'b0001);
    serviceOne(waited);
    checkOutput("req_to_go", 32'(waited), 32'd2);
    pushXfer(2'd0, 32'h1000, 32'h2002, 2'd1, 4'b0001);
    pulseReq(4'b0001);
    serviceOne(waited);
    readCheck("ch0_dmad", 8'h10, 32'h2004);
    readCheck("ch0_dmac", 8'h20, 32'd0);
    readCheck("ch0_dmas", 8'h00, 32'h1000);

    // Simultaneous requests on channels 1 and 3
    writeReg(8'h14, 32'h3000);
    writeReg(8'h24, 32'd5);
    writeReg(8'h26, 32'h0A);
    writeReg(8'h0C, 32'h4000);
    writeReg(8'h1C, 32'h5000);
    writeReg(8'h2C, 32'd1);
    writeReg(8'h2E, 32'h04);
    pushXfer(2'd1, 32'h00123456, 32'h3000, 2'd2, 4'b0000);
    pushXfer(2'd3, 32'h4000, 32'h5000, 2'd0, 4'b1000);
    pulseReq(4'b1010);
    serviceOne(waited);
    serviceOne(waited);
    go_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (dma_go) go_cnt++;
      tick();
    end
    checkOutput("no_extra_go", 32'(go_cnt), 32'd0);
    readCheck("ch1_dmas", 8'h04, 32'h0012345A);
    readCheck("ch1_dmac", 8'h24, 32'd4);
    readCheck("ch3_dmad", 8'h1C, 32'h4FFF);
    readCheck("ch3_dmac", 8'h2C, 32'd0);

    // Counter mode on channel 2: no bus transfer, source wraps
    writeReg(8'h08, 32'hFFFFFFFF);
    writeReg(8'h18, 32'h1234);
    writeReg(8'h28, 32'd3);
    writeReg(8'h2A, 32'h14);
    pulseReq(4'b0100);
    go_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (dma_go) go_cnt++;
      tick();
    end
    checkOutput("cnt_no_go", 32'(go_cnt), 32'd0);
    checkOutput("cnt_ch",    32'(dma_ch), 32'd2);
    checkOutput("cnt_src",   dma_src,     32'hFFFFFFFF);
    readCheck("cnt_dmas", 8'h08, 32'd0);
    readCheck("cnt_dmac", 8'h28, 32'd2);

    // A write with cen low must not land
    cen = 1'b0;
    writeReg(8'h18, 32'hDEAD);
    cen = 1'b1;
    readCheck("cen_gate", 8'h18, 32'h1234);

    // DMAC=0 start, long via size code 3, src decrement
    writeReg(8'h22, 32'h0F);
    pushXfer(2'd0, 32'h1000, 32'h2004, 2'd2, 4'b0000);
    pulseReq(4'b0001);
    serviceOne(waited);
    readCheck("wrap_dmac", 8'h20, 32'h0000FFFF);
    readCheck("wrap_dmas", 8'h00, 32'h0FFC);

    // CPU write to DMAC in the UPD cycle wins; mode 110 is fixed
    writeReg(8'h2C, 32'd1);
    writeReg(8'h2E, 32'h18);
    pulseReq(4'b1000);
    waitGo(waited);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    writeReg(8'h2C, 32'h77);
    readCheck("coll_dmac", 8'h2C, 32'h77);
    readCheck("fixed_dmas", 8'h0C, 32'h4000);
    readCheck("fixed_dmad", 8'h1C, 32'h4FFF);

    // INTNEST counting, saturation and write priority
    nest_inc = 1'b1;
    repeat (3) tick();
    nest_inc = 1'b0; nest_dec = 1'b1;
    tick();
    nest_inc = 1'b1;
    tick();
    nest_inc = 1'b0; nest_dec = 1'b0;
    readCheck("nest_two", 8'h3C, 32'd2);
    writeReg(8'h3C, 32'd0);
    nest_dec = 1'b1;
    tick();
    nest_dec = 1'b0;
    readCheck("nest_floor", 8'h3C, 32'd0);
    nest_inc = 1'b1;
    writeReg(8'h3C, 32'h10);
    nest_inc = 1'b0;
    readCheck("nest_wr_wins", 8'h3C, 32'h10);
    writeReg(8'h3C, 32'hFFFF);
    nest_inc = 1'b1;
    tick();
    nest_inc = 1'b0;
    readCheck("nest_ceiling", 8'h3C, 32'hFFFF);

    // Reset while a transfer waits for its ack
    pulseReq(4'b0001);
    waitGo(waited);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_wait_go",  32'(dma_go), 32'd0);
    checkOutput("rst_wait_src", dma_src,     32'd0);
    go_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (dma_go) go_cnt++;
      tick();
    end
    checkOutput("rst_pend_clear", 32'(go_cnt), 32'd0);
    readCheck("rst_wait_nest", 8'h3C, 32'd0);
    readCheck("rst_wait_dmas", 8'h00, 32'd0);
    readCheck("rst_wait_dmac", 8'h2C, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
